// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and Gray/binary pointer helpers for the async FIFO.
// Helpers work on a 32-bit zero-extended value, so any pointer width up to 32 can use them.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_PTR_CALC_W = 32;

  function automatic logic [FIFO_PTR_CALC_W-1:0] bin2gray(input logic [FIFO_PTR_CALC_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros of a zero-extended Gray value decode to zeros, so truncating the result is exact.
  function automatic logic [FIFO_PTR_CALC_W-1:0] gray2bin(input logic [FIFO_PTR_CALC_W-1:0] g);
    logic [FIFO_PTR_CALC_W-1:0] b;
    b[FIFO_PTR_CALC_W-1] = g[FIFO_PTR_CALC_W-1];
    for (int i = FIFO_PTR_CALC_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - write-domain pointer and full flag of the async FIFO.
// Optional walmost_full output and AFULL_THRESH parameter exist only with FIFO_ALMOST_FULL_EN.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH
`ifdef FIFO_ALMOST_FULL_EN
  ,
  parameter int AFULL_THRESH = 6
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_inc,
  input  logic [ADDR_WIDTH:0]   rq2_rptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wen,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic                  walmost_full
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic          wfull_q, wfull_d;
  logic          accept;

  assign accept = write_inc & ~wfull_q;

  // Full when the write pointer has lapped the read pointer once: top two Gray bits inverted.
  always_comb begin
    wbin_d  = wbin_q + PW'(accept);
    wptr_d  = PW'(bin2gray(FIFO_PTR_CALC_W'(wbin_d)));
    wfull_d = (wptr_d == {~rq2_rptr[PW-1], ~rq2_rptr[PW-2], rq2_rptr[PW-3:0]});
  end

`ifdef FIFO_ALMOST_FULL_EN
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] level_d;
  logic          walmost_full_q, walmost_full_d;

  always_comb begin
    rbin_sync      = PW'(gray2bin(FIFO_PTR_CALC_W'(rq2_rptr)));
    level_d        = wbin_d - rbin_sync;
    walmost_full_d = (FIFO_PTR_CALC_W'(level_d) >= FIFO_PTR_CALC_W'(AFULL_THRESH));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      walmost_full_q <= 1'b0;
    end else begin
      walmost_full_q <= walmost_full_d;
    end
  end

  assign walmost_full = walmost_full_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      wfull_q <= wfull_d;
    end
  end

  assign waddr = wbin_q[ADDR_WIDTH-1:0];
  assign wen   = accept;
  assign wptr  = wptr_q;
  assign wfull = wfull_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb/tb_fifo_wptr_full.sv - scoreboard bench for fifo_wptr_full (ADDR_WIDTH=3).
// Also checks walmost_full (threshold 6) when built with FIFO_ALMOST_FULL_EN.
module tb_fifo_wptr_full;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       write_inc = 1'b0;
  logic [3:0] rq2_rptr = 4'd0;
  logic [2:0] waddr;
  logic       wen;
  logic [3:0] wptr;
  logic       wfull;
  logic       walmost_full;

`ifdef FIFO_ALMOST_FULL_EN
  fifo_wptr_full #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
    .clock(clock), .reset(reset), .write_inc(write_inc), .rq2_rptr(rq2_rptr),
    .waddr(waddr), .wen(wen), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full));
`else
  fifo_wptr_full #(.ADDR_WIDTH(3)) dut (
    .clock(clock), .reset(reset), .write_inc(write_inc), .rq2_rptr(rq2_rptr),
    .waddr(waddr), .wen(wen), .wptr(wptr), .wfull(wfull));
  assign walmost_full = 1'b0;
`endif

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] wptr;
    logic       wfull;
    logic [2:0] waddr;
    logic       wen;
    logic       af;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model: write count and read count modulo 16, occupancy is their difference.
  int   wcount = 0;
  int   rc_cur = 0;
  bit   mfull = 0;
  bit   maf = 0;
  int   lag_hist[$];

  function automatic logic [3:0] gray(input int n);
    int m;
    m = n % 16;
    return 4'(m ^ (m / 2));
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic step(input bit wi, input int rc);
    exp_t e;
    int   occ;
    @(posedge clock);
    #1;
    write_inc = wi;
    rq2_rptr  = gray(rc);
    rc_cur    = rc;
    e.wptr  = gray(wcount);
    e.wfull = mfull;
    e.waddr = 3'(wcount % 8);
    e.wen   = wi && !mfull;
    e.af    = maf;
    exp_q.push_back(e);
    if (wi && !mfull) wcount = (wcount + 1) % 16;
    occ   = (wcount - rc + 16) % 16;
    mfull = (occ == 8);
    maf   = (occ >= 6);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #3;
    write_inc = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_wptr", int'(wptr), 0);
    chk("rst_wfull", int'(wfull), 0);
    chk("rst_waddr", int'(waddr), 0);
`ifdef FIFO_ALMOST_FULL_EN
    chk("rst_afull", int'(walmost_full), 0);
`endif
    @(posedge clock);
    #2;
    write_inc = 1'b0;
    rq2_rptr = 4'd0;
    reset = 1'b0;
    wcount = 0; rc_cur = 0; mfull = 0; maf = 0;
  endtask

  logic [3:0] prev_wptr;
  bit         have_prev = 0;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      have_prev = 0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wptr", int'(wptr), int'(e.wptr));
      chk("wfull", int'(wfull), int'(e.wfull));
      chk("waddr", int'(waddr), int'(e.waddr));
      chk("wen", int'(wen), int'(e.wen));
`ifdef FIFO_ALMOST_FULL_EN
      chk("walmost_full", int'(walmost_full), int'(e.af));
`endif
      if (have_prev) chk("wptr_onebit", int'($countones(wptr ^ prev_wptr) <= 1), 1);
      prev_wptr = wptr;
      have_prev = 1;
    end
  end

  initial begin
    #12;
    reset = 1'b0;
    step(0, 0);
    // Fill, then three rejected writes while full.
    for (int i = 0; i < 8; i++) step(1, 0);
    for (int i = 0; i < 3; i++) step(1, 0);
    // Release coinciding with a write: that write is still rejected, the next one lands.
    step(1, 1);
    step(1, 1);
    step(0, 1);
    step(0, 1);
    do_reset();
    // Sixteen writes with the read pointer trailing by two cycles.
    lag_hist.delete();
    for (int i = 0; i < 18; i++) begin
      int rc;
      lag_hist.push_back(wcount);
      rc = (lag_hist.size() >= 3) ? lag_hist[lag_hist.size() - 3] : 0;
      step(i < 16, rc);
    end
    // Random writes against a read pointer that only advances one step at a time.
    for (int i = 0; i < 400; i++) begin
      int rc;
      rc = rc_cur;
      if (rc != wcount && $urandom_range(2) == 0) rc = (rc + 1) % 16;
      step($urandom_range(3) != 0, rc);
    end
    step(0, rc_cur);
    repeat (2) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
